// File: rtl/usb_pkg.sv
// Shared types and line encodings for the USB bit-stuffing / NRZI transmitter.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        STUFF,
        EOP1,
        EOP2,
        EOPJ
    } state_t;

    localparam int unsigned ONES_W      = 3;
    localparam int unsigned STUFF_LIMIT = 6;

    // Line encodings as {dp, dm}
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_bit_stuff_nrzi_if.sv
// Serial bit handshake from the upstream stage plus the D+/D- line and status.
interface usb_bit_stuff_nrzi_if;

    logic bIn;
    logic inAvail;
    logic inReady;
    logic dp;
    logic dm;
    logic sending;
    logic done;

    modport master (
        output bIn, inAvail,
        input  inReady, dp, dm, sending, done
    );

    modport slave (
        input  bIn, inAvail,
        output inReady, dp, dm, sending, done
    );

endinterface

// File: rtl/nrzi_enc.sv
// NRZI level register and registered D+/D- drive (J/K data, SE0, forced J).
module nrzi_enc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    input  logic se0,
    input  logic forceJ,
    output logic dp,
    output logic dm
);

    logic  nrzi;
    logic  nrzi_n;
    line_t line_n;

    // Forced J also re-arms the level to J for the next packet
    always_comb begin
        nrzi_n = nrzi;
        line_n = nrzi ? LINE_J : LINE_K;
        if (forceJ) begin
            nrzi_n = 1'b1;
            line_n = LINE_J;
        end else if (se0) begin
            line_n = LINE_SE0;
        end else if (toggle) begin
            nrzi_n = ~nrzi;
            line_n = nrzi_n ? LINE_J : LINE_K;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrzi <= 1'b1;
            dp   <= 1'b1;
            dm   <= 1'b0;
        end else begin
            nrzi     <= nrzi_n;
            {dp, dm} <= line_n;
        end
    end

endmodule

// File: rtl/usb_bit_stuff_nrzi.sv
// USB transmit back end: bit stuffing after six 1s, NRZI line coding and EOP generation.
module usb_bit_stuff_nrzi
    import usb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    usb_bit_stuff_nrzi_if.slave   bus
);

    state_t            state;
    state_t            state_n;
    logic [ONES_W-1:0] ones_cnt;
    logic [ONES_W-1:0] ones_cnt_n;
    logic              accept;
    logic              toggle;
    logic              se0;
    logic              force_j;

    assign bus.inReady = (state == IDLE) || (state == SEND);
    assign accept      = bus.inReady && bus.inAvail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ones_cnt    <= '0;
            bus.sending <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_n;
            ones_cnt    <= ones_cnt_n;
            bus.sending <= (state_n != IDLE);
            bus.done    <= (state_n == EOPJ);
        end
    end

    always_comb begin
        state_n    = state;
        ones_cnt_n = ones_cnt;
        toggle     = 1'b0;
        se0        = 1'b0;
        force_j    = 1'b0;
        case (state)
            IDLE, SEND: begin
                if (accept) begin
                    toggle = ~bus.bIn;
                    if (bus.bIn) begin
                        ones_cnt_n = ones_cnt + ONES_W'(1);
                        state_n    = (ones_cnt_n == ONES_W'(STUFF_LIMIT)) ? STUFF : SEND;
                    end else begin
                        ones_cnt_n = '0;
                        state_n    = SEND;
                    end
                end else if (state == SEND) begin
                    se0     = 1'b1;
                    state_n = EOP1;
                end else begin
                    force_j = 1'b1;
                end
            end
            STUFF: begin
                toggle     = 1'b1;
                ones_cnt_n = '0;
                state_n    = bus.inAvail ? SEND : EOP1;
            end
            EOP1: begin
                se0     = 1'b1;
                state_n = EOP2;
            end
            EOP2: begin
                force_j = 1'b1;
                state_n = EOPJ;
            end
            EOPJ: begin
                force_j    = 1'b1;
                ones_cnt_n = '0;
                state_n    = IDLE;
            end
            default: begin
                force_j = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    nrzi_enc u_nrzi_enc (
        .clk    (clk),
        .rst    (rst),
        .toggle (toggle),
        .se0    (se0),
        .forceJ (force_j),
        .dp     (bus.dp),
        .dm     (bus.dm)
    );

endmodule

// File: tb/tb_usb_bit_stuff_nrzi.sv
// Bench for usb_bit_stuff_nrzi: directed and random packets against a line-level reference model.
module tb_usb_bit_stuff_nrzi;

    typedef logic [4:0] smp_t;                 // {dp, dm, inReady, sending, done}
    localparam smp_t S_IDLE = 5'b10100;

    logic clk;
    logic rst;

    usb_bit_stuff_nrzi_if bus ();

    usb_bit_stuff_nrzi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    smp_t cap[$];
    smp_t exp_q[$];
    logic pa[$];
    logic pb[$];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic smp_t now_smp();
        return {bus.dp, bus.dm, bus.inReady, bus.sending, bus.done};
    endfunction

    // One clock: record the line at the falling edge, then drive the inputs
    task automatic cycle(input logic avail, input logic b, output logic rdy);
        @(negedge clk);
        cap.push_back(now_smp());
        rdy         = bus.inReady;
        bus.inAvail = avail;
        bus.bIn     = b;
    endtask

    task automatic send_bits(input logic bits[$]);
        int   idx   = 0;
        int   guard = 0;
        logic rdy;
        while (idx < bits.size()) begin
            cycle(1'b1, bits[idx], rdy);
            if (rdy) idx++;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 8'(idx), 8'(bits.size()));
                break;
            end
        end
    endtask

    task automatic mk(output logic q[$], input logic [31:0] v, input int n);
        q.delete();
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    endtask

    // Expected line for one packet: stuffed stream NRZI-coded from J, then the EOP
    task automatic model_packet(input logic bits[$]);
        logic s[$];
        bit   st[$];
        int   run = 0;
        logic lvl = 1'b1;
        logic rdy;
        foreach (bits[i]) begin
            s.push_back(bits[i]);
            st.push_back(1'b0);
            run = bits[i] ? run + 1 : 0;
            if (run == 6) begin
                s.push_back(1'b0);
                st.push_back(1'b1);
                run = 0;
            end
        end
        foreach (s[i]) begin
            if (!s[i]) lvl = ~lvl;
            if (st[i]) rdy = (i != s.size() - 1);
            else       rdy = !((i + 1 < s.size()) && st[i + 1]);
            exp_q.push_back({lvl, ~lvl, rdy, 1'b1, 1'b0});
        end
        if (!st[s.size() - 1]) exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b10011);
    endtask

    task automatic run_case(input string name, input bit two, input bit hold);
        logic rdy;
        cap.delete();
        exp_q.delete();
        exp_q.push_back(S_IDLE);
        send_bits(pa);
        cycle(1'b0, 1'b0, rdy);
        model_packet(pa);
        if (two) begin
            if (!hold) repeat (3) cycle(1'b0, 1'b0, rdy);
            exp_q.push_back(S_IDLE);
            send_bits(pb);
            cycle(1'b0, 1'b0, rdy);
            model_packet(pb);
        end
        repeat (6) cycle(1'b0, 1'b0, rdy);
        chk({name, "_len"}, 8'(cap.size() >= exp_q.size()), 8'd1);
        while (exp_q.size() < cap.size()) exp_q.push_back(S_IDLE);
        foreach (cap[i]) chk($sformatf("%s_s%0d", name, i), 8'(cap[i]), 8'(exp_q[i]));
    endtask

    initial begin
        logic rdy;
        int   n;
        bus.inAvail = 1'b0;
        bus.bIn     = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", 8'(now_smp()), 8'(S_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_state", 8'(now_smp()), 8'(S_IDLE));

        mk(pa, 32'b001, 3);            run_case("p001", 1'b0, 1'b0);
        mk(pa, 32'b0_11111111, 9);     run_case("eight_ones", 1'b0, 1'b0);
        mk(pa, 32'b0_111111, 7);       run_case("stuff_last", 1'b0, 1'b0);
        mk(pa, 32'b111110, 6);         run_case("five_ones", 1'b0, 1'b0);
        mk(pa, 32'hFFF, 12);           run_case("twelve_ones", 1'b0, 1'b0);
        mk(pa, 32'b010, 3);
        mk(pb, 32'b11, 2);             run_case("hold_avail", 1'b1, 1'b1);
        mk(pa, 32'b0_111111, 7);
        mk(pb, 32'b10, 2);             run_case("hold_stuff", 1'b1, 1'b1);

        // Asynchronous reset while the third bit is on offer
        mk(pa, 32'b01101, 5);
        for (int i = 0; i < 3; i++) cycle(1'b1, pa[i], rdy);
        chk("pre_rst_dp", 8'(bus.dp), 8'd0);
        chk("pre_rst_sending", 8'(bus.sending), 8'd1);
        #2 rst = 1'b1;
        #1 chk("rst_mid", 8'(now_smp()), 8'(S_IDLE));
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, rdy);
            chk("rst_hold", 8'(now_smp()), 8'(S_IDLE));
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.inAvail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, rdy);
            chk("rst_after", 8'(now_smp()), 8'(S_IDLE));
        end

        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(1, 20));
            pa.delete();
            for (int j = 0; j < n; j++) pa.push_back(logic'($urandom_range(0, 3) != 0));
            n = int'($urandom_range(1, 12));
            pb.delete();
            for (int j = 0; j < n; j++) pb.push_back(logic'($urandom_range(0, 3) != 0));
            run_case($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
